// File: rtl/oam_dma_controller_pkg.sv
// ---------------------------------------------------------------------------
// oam_dma_controller_pkg
// Shared constants and helpers for the OAM DMA sequencer:
//   IOREG_DMA            - I/O register that starts a transfer (FF46)
//   HRAM_START/HRAM_END  - high RAM window the CPU keeps during a transfer
//   OAM_SIZE             - bytes copied per transfer
//   read_sel_t           - source of the byte returned to the CPU next cycle
//   map_source()         - folds the echo-RAM pages E0-FF back onto C0-DF
//   in_hram()            - address lies inside high RAM
// ---------------------------------------------------------------------------
package oam_dma_controller_pkg;

  localparam logic [15:0] IOREG_DMA  = 16'hFF46;
  localparam logic [15:0] HRAM_START = 16'hFF80;
  localparam logic [15:0] HRAM_END   = 16'hFFFE;
  localparam int          OAM_SIZE   = 160;

  typedef enum logic [1:0] {
    SEL_ZERO    = 2'd0,
    SEL_SOURCE  = 2'd1,
    SEL_BLOCKED = 2'd2,
    SEL_MEMORY  = 2'd3
  } read_sel_t;

  // Pages E0-FF are an echo of C0-DF, so the DMA reads the real RAM page.
  function automatic logic [7:0] map_source(input logic [7:0] src);
    return (src >= 8'hE0) ? (src - 8'h20) : src;
  endfunction

  function automatic logic in_hram(input logic [15:0] addr);
    return (addr >= HRAM_START) && (addr <= HRAM_END);
  endfunction

endpackage

// File: rtl/oam_dma_controller.sv
// ---------------------------------------------------------------------------
// oam_dma_controller
// DMG-style OAM DMA. A CPU write to FF46 copies OAM_BYTES bytes from
// {source,8'h00} into OAM. While a transfer runs the controller owns the
// memory bus on the fetch phase of every byte and the CPU only sees HRAM and
// FF46; other reads return 8'hFF and other writes are dropped.
// Ports:
//   clk, reset                  clock, async active-high reset
//   cpuAddress/DataOut/Write    CPU bus request
//   cpuDataIn                   read data back to the CPU (1-cycle latency)
//   memAddress/DataW/Write      request forwarded to the memory decoder
//   memDataR                    registered read data from the decoder
//   oamAddress/DataW/Write      OAM write port (single-cycle strobe)
//   dmaActive                   high from the FF46 write to the last OAM byte
// ---------------------------------------------------------------------------
module oam_dma_controller
  import oam_dma_controller_pkg::*;
#(
  parameter int BYTE_PERIOD = 4,
  parameter int OAM_BYTES   = OAM_SIZE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpuAddress,
  input  logic [7:0]  cpuDataOut,
  input  logic        cpuWrite,
  output logic [7:0]  cpuDataIn,
  output logic [15:0] memAddress,
  output logic [7:0]  memDataW,
  output logic        memWrite,
  input  logic [7:0]  memDataR,
  output logic [7:0]  oamAddress,
  output logic [7:0]  oamDataW,
  output logic        oamWrite,
  output logic        dmaActive
);

  localparam int PW = (BYTE_PERIOD > 1) ? $clog2(BYTE_PERIOD) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;

  localparam logic [PW-1:0] PHASE_FETCH = '0;
  localparam logic [PW-1:0] PHASE_WRITE = PW'(1);
  localparam logic [PW-1:0] PHASE_LAST  = PW'(BYTE_PERIOD - 1);
  localparam logic [7:0]    INDEX_LAST  = 8'(OAM_BYTES - 1);

  logic [1:0]    state;
  logic [7:0]    dma_source;
  logic [7:0]    index;
  logic [PW-1:0] phase;
  read_sel_t     read_sel;

  logic trigger;
  logic cpu_hram;
  logic dma_fetch;

  assign trigger   = cpuWrite && (cpuAddress == IOREG_DMA);
  assign cpu_hram  = in_hram(cpuAddress);
  assign dma_fetch = (state == ST_XFER) && (phase == PHASE_FETCH);

  // Bus arbitration: the DMA only takes the address on the fetch phase.
  // Everywhere else the CPU address goes through, but while a transfer is
  // running only HRAM writes survive. FF46 is a controller register and is
  // never written to memory.
  always_comb begin
    memAddress = cpuAddress;
    memDataW   = cpuDataOut;
    memWrite   = 1'b0;
    if (dma_fetch) begin
      memAddress = {map_source(dma_source), index};
    end else if (state == ST_IDLE) begin
      memWrite = cpuWrite && (cpuAddress != IOREG_DMA);
    end else begin
      memWrite = cpuWrite && cpu_hram;
    end
  end

  // Sequencer. A trigger always wins over whatever the FSM would otherwise
  // do, which gives restart-from-zero and lets a trigger on the final byte
  // keep dmaActive high. oamWrite is registered at the end of phase 1, one
  // cycle after the fetch, when the decoder's registered data is valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      dma_source <= 8'h00;
      index      <= 8'h00;
      phase      <= '0;
      oamAddress <= 8'h00;
      oamDataW   <= 8'h00;
      oamWrite   <= 1'b0;
      dmaActive  <= 1'b0;
    end else begin
      oamWrite <= 1'b0;
      if (trigger) begin
        dma_source <= cpuDataOut;
        index      <= 8'h00;
        phase      <= '0;
        state      <= ST_START;
        dmaActive  <= 1'b1;
      end else begin
        case (state)
          ST_START: begin
            if (phase == PHASE_LAST) begin
              phase <= '0;
              state <= ST_XFER;
            end else begin
              phase <= phase + PW'(1);
            end
          end
          ST_XFER: begin
            if (phase == PHASE_WRITE) begin
              oamDataW   <= memDataR;
              oamAddress <= index;
              oamWrite   <= 1'b1;
            end
            if (phase == PHASE_LAST) begin
              phase <= '0;
              if (index == INDEX_LAST) begin
                index     <= 8'h00;
                state     <= ST_IDLE;
                dmaActive <= 1'b0;
              end else begin
                index <= index + 8'h01;
              end
            end else begin
              phase <= phase + PW'(1);
            end
          end
          ST_IDLE: begin
            phase <= '0;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // The read source is chosen from this cycle's address and registered on
  // the same edge at which the decoder registers its address, so the choice
  // lines up with memDataR on the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_sel <= SEL_ZERO;
    end else if (cpuAddress == IOREG_DMA) begin
      read_sel <= SEL_SOURCE;
    end else if ((state != ST_IDLE) && !cpu_hram) begin
      read_sel <= SEL_BLOCKED;
    end else begin
      read_sel <= SEL_MEMORY;
    end
  end

  always_comb begin
    cpuDataIn = 8'h00;
    case (read_sel)
      SEL_SOURCE:  cpuDataIn = dma_source;
      SEL_BLOCKED: cpuDataIn = 8'hFF;
      SEL_MEMORY:  cpuDataIn = memDataR;
      default:     cpuDataIn = 8'h00;
    endcase
  end

endmodule
